amba3_apb_slave_regfile: RTL and testbench
==========================================

# amba3_apb_slave_regfile

Synthesizable AMBA 3 APB completer: a bank of REG_COUNT data-width registers written and read over APB, with registered PREADY and optional fixed wait-state insertion. It is the RTL responder the APB master BFM tasks drive in block-level benches, and the register front-end for peripherals. Register contents and per-register write strobes are exported to the peripheral core.

## Interface
- ADDR_SIZE, 32: paddr width.
- DATA_SIZE, 32: pwdata/prdata width; 8, 16 or 32.
- REG_COUNT, 16: number of registers; power of two, 2..256.
- WAIT_CYCLES, 2: wait states per transfer, 0..15; used only with the configuration macro.
- Derived: BYTE_BITS = log2(DATA_SIZE/8), IDX_BITS = log2(REG_COUNT).

Ports:
- pclk  input  1  clock.
- preset_n  input  1  reset; synchronous, active-low.
- paddr  input  ADDR_SIZE  byte address.
- psel  input  1  select.
- penable  input  1  access phase.
- pwrite  input  1  1 = write, 0 = read.
- pwdata  input  DATA_SIZE  write data.
- pready  output  1  transfer-complete, registered.
- prdata  output  DATA_SIZE  read data, registered.
- reg_q  output  REG_COUNT*DATA_SIZE  register contents; register i at [i*DATA_SIZE +: DATA_SIZE].
- wr_stb  output  REG_COUNT  one-cycle pulse on the cycle after register i is written.

## Operation
- Decode: idx = paddr[BYTE_BITS +: IDX_BITS]. In range iff paddr[ADDR_SIZE-1 : BYTE_BITS+IDX_BITS] == 0. paddr[BYTE_BITS-1:0] ignored.
- Out-of-range write: no register changes, no wr_stb. Out-of-range read: prdata = 0. Both still complete normally.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: at an edge sampling psel=1, penable=0: latch addr/pwrite/pwdata. Go to ACCESS with pready<=1 if the wait count is 0. Otherwise go to WAIT with cnt<=wait count.
  - WAIT: cnt decrements each edge. At the edge where cnt==1: pready<=1, go to ACCESS.
  - ACCESS: at the edge sampling psel=1, penable=1, pready=1, the transfer completes. A write commits pwdata latched at setup to reg[idx]. pready<=0, prdata<=0, go to IDLE.
- Read data: prdata is loaded with reg[idx] (or 0) on the same edge that sets pready<=1. It is otherwise 0.
- Abort: psel sampled 0 in WAIT or ACCESS: go to IDLE, pready<=0, prdata<=0, no write, no wr_stb.
- Back-to-back: a setup phase in the cycle after completion is accepted from IDLE with no gap.
- In ACCESS/WAIT, changes on paddr/pwdata are ignored; latched values are used.

## Timing
- Reset, sampled at a pclk edge with preset_n=0:
  - pready=0, prdata=0, wr_stb=0, all registers=0, FSM=IDLE, cnt=0.
  - Any in-flight transfer is dropped without a write.
- Zero waits: setup cycle T, access cycle T+1 with pready=1, completion at the end of T+1. Two cycles per transfer.
- N waits: pready rises in access cycle N+1. Total N+2 cycles.
- Write visible on reg_q the cycle after completion. wr_stb[idx] is high for exactly that cycle.
- A read of a register in the cycle after it was written returns the new value.

## Configuration
- AMBA3_APB_SLAVE_WAIT_EN defined: wait count = WAIT_CYCLES, and WAIT state and cnt are implemented.
- Not defined: wait count is fixed at 0, and WAIT state and cnt are removed. WAIT_CYCLES is ignored.

## Test plan
- Zero waits (macro off):
  - Stimulus: write 0xDEADBEEF to 0x04, then read 0x04.
  - Required response:
    - pready=1 in each access cycle.
    - reg_q[63:32]=0xDEADBEEF.
    - wr_stb=0x0002 for one cycle.
    - prdata=0xDEADBEEF with pready.
- Out of range (REG_COUNT=16):
  - Stimulus: write 0x12345678 to 0x40, then read 0x40.
  - Required response: no reg_q change, wr_stb=0, read returns 0x00000000, both complete in 2 cycles.
- Wait states (macro on, WAIT_CYCLES=2):
  - Stimulus: read 0x08 holding 0xA5A5A5A5.
  - Required response: pready=0 for access cycles 1–2, pready=1 with prdata=0xA5A5A5A5 in cycle 3, total 4 cycles.
- Abort (macro on, WAIT_CYCLES=3):
  - Stimulus: write 0x1 to 0x0, drop psel in access cycle 2.
  - Required response: reg 0 stays 0, wr_stb=0, FSM back in IDLE, and the next transfer is accepted normally.
- Reset mid-transfer:
  - Stimulus: assert preset_n=0 during the access cycle of a write of 0xFFFFFFFF to 0x0C.
  - Required response: all outputs and registers are 0 after the edge, and reg 3 is not written.
- Back-to-back:
  - Stimulus: write 0x11 to 0x00, then immediately write 0x22 to 0x04, then read 0x00.
  - Required response: both writes land, wr_stb pulses 0x0001 then 0x0002, and the read returns 0x11.

Source files
------------

// File: rtl/amba3_apb_slave_regfile.sv
// APB3 completer: REG_COUNT x DATA_SIZE register bank with per-register write strobes to the core.
// Latency: 2 cycles per transfer (setup + access); AMBA3_APB_SLAVE_WAIT_EN adds WAIT_CYCLES wait states.
// Backpressure: registered pready stalls the requester; dropping psel mid-transfer aborts it with no write.
module amba3_apb_slave_regfile #(
   parameter int ADDR_SIZE   = 32,
   parameter int DATA_SIZE   = 32,
   parameter int REG_COUNT   = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                           pclk,
   input  logic                           preset_n,
   input  logic [ADDR_SIZE-1:0]           paddr,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [DATA_SIZE-1:0]           pwdata,
   output logic                           pready,
   output logic [DATA_SIZE-1:0]           prdata,
   output logic [REG_COUNT*DATA_SIZE-1:0] reg_q,
   output logic [REG_COUNT-1:0]           wr_stb
);

   localparam int BYTE_BITS = $clog2(DATA_SIZE / 8);
   localparam int IDX_BITS  = $clog2(REG_COUNT);
   localparam int LOW_BITS  = BYTE_BITS + IDX_BITS;
   // Address bits above the register window; any of them set means out of range.
   localparam logic [ADDR_SIZE-1:0] HIGH_MASK =
      ~((ADDR_SIZE'(1) << LOW_BITS) - ADDR_SIZE'(1));

`ifdef AMBA3_APB_SLAVE_WAIT_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd2
   } state_t;
`endif

   state_t                 state;
   logic [DATA_SIZE-1:0]   regs [REG_COUNT];
   logic [IDX_BITS-1:0]    lat_idx;
   logic                   lat_hit;
   logic                   lat_write;
   logic [DATA_SIZE-1:0]   lat_wdata;
`ifdef AMBA3_APB_SLAVE_WAIT_EN
   logic [3:0]             cnt;
   logic [DATA_SIZE-1:0]   lat_rd;
`endif

   logic [IDX_BITS-1:0]    bus_idx;
   logic                   bus_hit;
   logic [DATA_SIZE-1:0]   bus_rd;

   // Decode the live bus address (used at setup) and read the selected register.
   always_comb begin
      bus_idx = paddr[BYTE_BITS +: IDX_BITS];
      bus_hit = ((paddr & HIGH_MASK) == '0);
      bus_rd  = bus_hit ? regs[bus_idx] : '0;
   end

`ifdef AMBA3_APB_SLAVE_WAIT_EN
   // Read data for the end of the wait period comes from the latched address.
   always_comb begin
      lat_rd = lat_hit ? regs[lat_idx] : '0;
   end
`endif

   // Transfer FSM: latches the setup phase, counts wait states, commits writes on completion.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state     <= ST_IDLE;
         pready    <= 1'b0;
         prdata    <= '0;
         wr_stb    <= '0;
         lat_idx   <= '0;
         lat_hit   <= 1'b0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
`ifdef AMBA3_APB_SLAVE_WAIT_EN
         cnt       <= '0;
`endif
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else begin
         wr_stb <= '0;
         case (state)
            ST_IDLE: begin
               if (psel && !penable) begin
                  lat_idx   <= bus_idx;
                  lat_hit   <= bus_hit;
                  lat_write <= pwrite;
                  lat_wdata <= pwdata;
`ifdef AMBA3_APB_SLAVE_WAIT_EN
                  if (WAIT_CYCLES == 0) begin
                     state  <= ST_ACCESS;
                     pready <= 1'b1;
                     prdata <= pwrite ? '0 : bus_rd;
                  end else begin
                     state  <= ST_WAIT;
                     cnt    <= 4'(WAIT_CYCLES);
                  end
`else
                  state  <= ST_ACCESS;
                  pready <= 1'b1;
                  prdata <= pwrite ? '0 : bus_rd;
`endif
               end
            end
`ifdef AMBA3_APB_SLAVE_WAIT_EN
            ST_WAIT: begin
               if (!psel) begin
                  state  <= ST_IDLE;
                  pready <= 1'b0;
                  prdata <= '0;
                  cnt    <= '0;
               end else if (cnt == 4'd1) begin
                  state  <= ST_ACCESS;
                  pready <= 1'b1;
                  prdata <= lat_write ? '0 : lat_rd;
                  cnt    <= '0;
               end else begin
                  cnt    <= cnt - 4'd1;
               end
            end
`endif
            ST_ACCESS: begin
               if (!psel) begin
                  state  <= ST_IDLE;
                  pready <= 1'b0;
                  prdata <= '0;
               end else if (penable && pready) begin
                  if (lat_write && lat_hit) begin
                     regs[lat_idx]   <= lat_wdata;
                     wr_stb[lat_idx] <= 1'b1;
                  end
                  state  <= ST_IDLE;
                  pready <= 1'b0;
                  prdata <= '0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               pready <= 1'b0;
               prdata <= '0;
            end
         endcase
      end
   end

   // Flatten the register bank onto the export bus.
   for (genvar g = 0; g < REG_COUNT; g++) begin : g_regq
      assign reg_q[g*DATA_SIZE +: DATA_SIZE] = regs[g];
   end

endmodule

// File: tb/tb_amba3_apb_slave_regfile.sv
// Directed bench for amba3_apb_slave_regfile: writes, reads, out-of-range, back-to-back, abort, reset.
// Builds with or without AMBA3_APB_SLAVE_WAIT_EN; expected cycle counts follow the wait setting.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
module tb_amba3_apb_slave_regfile;

   localparam int RC = 16;
`ifdef AMBA3_APB_SLAVE_WAIT_EN
   localparam int WAITS = 2;
`else
   localparam int WAITS = 0;
`endif
   localparam int EXP_CYC = WAITS + 2;

   logic              pclk = 1'b0;
   logic              preset_n;
   logic [31:0]       paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic              pready;
   logic [31:0]       prdata;
   logic [RC*32-1:0]  reg_q;
   logic [RC-1:0]     wr_stb;

   int                checks   = 0;
   int                failures = 0;
   logic [RC*32-1:0]  exp_q;
   logic [31:0]       rd;
   int                cyc;
   logic [15:0]       stb;

   always #5 pclk = ~pclk;

   amba3_apb_slave_regfile #(
      .ADDR_SIZE(32), .DATA_SIZE(32), .REG_COUNT(RC), .WAIT_CYCLES(WAITS)
   ) dut (
      .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pready(pready),
      .prdata(prdata), .reg_q(reg_q), .wr_stb(wr_stb)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      checks++;
      assert (reg_q === exp_q) else begin
         failures++;
         $error("FAIL %s: reg_q observed=%h expected=%h", tag, reg_q, exp_q);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // One full APB transfer; the bus is scrambled during access to prove latching.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int ncyc, output logic [15:0] stb_o);
      logic got;
      got     = 1'b0;
      rdata   = '0;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      ncyc    = 1;
      tick();
      penable = 1'b1;
      paddr   = 32'hFFFF_FFF0;
      pwdata  = ~wdata;
      for (int i = 0; i < 40; i++) begin
         ncyc++;
         if (pready === 1'b1) begin
            rdata = prdata;
            got   = 1'b1;
            break;
         end
         tick();
      end
      check("xfer_ready_seen", {31'b0, got}, 32'd1);
      tick();
      stb_o   = wr_stb;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      preset_n = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      exp_q = '0;
      repeat (3) tick();
      check("rst_pready", {31'b0, pready}, 32'd0);
      check("rst_prdata", prdata, 32'd0);
      check("rst_wr_stb", {16'b0, wr_stb}, 32'd0);
      check_regs("rst_regs");
      preset_n = 1'b1;
      tick();

      // Basic write then read of register 1.
      xfer(1'b1, 32'h04, 32'hDEADBEEF, rd, cyc, stb);
      exp_q[63:32] = 32'hDEADBEEF;
      check("wr1_cycles", cyc, EXP_CYC);
      check("wr1_stb", {16'b0, stb}, 32'h0002);
      check_regs("wr1_regs");
      check("wr1_regq_slice", reg_q[63:32], 32'hDEADBEEF);
      tick();
      check("wr1_stb_one_cycle", {16'b0, wr_stb}, 32'd0);
      xfer(1'b0, 32'h04, 32'h0, rd, cyc, stb);
      check("rd1_data", rd, 32'hDEADBEEF);
      check("rd1_cycles", cyc, EXP_CYC);
      check("rd1_prdata_cleared", prdata, 32'd0);
      check("rd1_no_stb", {16'b0, stb}, 32'd0);
      // Low byte-offset bits are ignored.
      xfer(1'b0, 32'h07, 32'h0, rd, cyc, stb);
      check("rd_offset_ignored", rd, 32'hDEADBEEF);

      // Out-of-range write and read.
      xfer(1'b1, 32'h40, 32'h12345678, rd, cyc, stb);
      check("oor_wr_cycles", cyc, EXP_CYC);
      check("oor_wr_stb", {16'b0, stb}, 32'd0);
      check_regs("oor_wr_regs");
      xfer(1'b0, 32'h40, 32'h0, rd, cyc, stb);
      check("oor_rd_data", rd, 32'd0);
      check("oor_rd_cycles", cyc, EXP_CYC);
      xfer(1'b1, 32'h8000_0000, 32'hCAFEF00D, rd, cyc, stb);
      check("oor_hi_stb", {16'b0, stb}, 32'd0);
      check_regs("oor_hi_regs");

      // Back-to-back transfers with no idle cycle between them.
      xfer(1'b1, 32'h00, 32'h11, rd, cyc, stb);
      check("b2b_stb0", {16'b0, stb}, 32'h0001);
      xfer(1'b1, 32'h04, 32'h22, rd, cyc, stb);
      check("b2b_stb1", {16'b0, stb}, 32'h0002);
      check("b2b_cycles", cyc, EXP_CYC);
      xfer(1'b0, 32'h00, 32'h0, rd, cyc, stb);
      check("b2b_rd0", rd, 32'h11);
      xfer(1'b0, 32'h04, 32'h0, rd, cyc, stb);
      check("b2b_rd1", rd, 32'h22);
      exp_q[31:0]  = 32'h11;
      exp_q[63:32] = 32'h22;
      check_regs("b2b_regs");

      // Register 2 write then read (exercises wait states when enabled).
      xfer(1'b1, 32'h08, 32'hA5A5A5A5, rd, cyc, stb);
      exp_q[95:64] = 32'hA5A5A5A5;
      check("r2_stb", {16'b0, stb}, 32'h0004);
      xfer(1'b0, 32'h08, 32'h0, rd, cyc, stb);
      check("r2_rd_data", rd, 32'hA5A5A5A5);
      check("r2_rd_cycles", cyc, EXP_CYC);

      // Abort: psel dropped before completion.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h1;
      tick();
`ifdef AMBA3_APB_SLAVE_WAIT_EN
      penable = 1'b1;
      tick();
      check("abort_not_ready", {31'b0, pready}, 32'd0);
`endif
      psel = 1'b0; penable = 1'b0;
      tick();
      check("abort_pready", {31'b0, pready}, 32'd0);
      check("abort_prdata", prdata, 32'd0);
      check("abort_stb", {16'b0, wr_stb}, 32'd0);
      tick();
      check("abort_stb_late", {16'b0, wr_stb}, 32'd0);
      check_regs("abort_regs");
      xfer(1'b0, 32'h00, 32'h0, rd, cyc, stb);
      check("abort_next_rd", rd, 32'h11);
      check("abort_next_cycles", cyc, EXP_CYC);

      // Reset during the access cycle of a write.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFFFFFFFF;
      tick();
      penable  = 1'b1;
      preset_n = 1'b0;
      tick();
      exp_q = '0;
      check("mrst_pready", {31'b0, pready}, 32'd0);
      check("mrst_prdata", prdata, 32'd0);
      check("mrst_stb", {16'b0, wr_stb}, 32'd0);
      check_regs("mrst_regs");
      preset_n = 1'b1;
      psel = 1'b0; penable = 1'b0;
      tick();
      check("mrst_stb_after", {16'b0, wr_stb}, 32'd0);
      check("mrst_reg3", reg_q[127:96], 32'd0);
      xfer(1'b0, 32'h0C, 32'h0, rd, cyc, stb);
      check("mrst_rd3", rd, 32'd0);
      check("mrst_rd_cycles", cyc, EXP_CYC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
